button_conditioner: RTL and testbench

- Upstream stage for the LED counter: turns raw, asynchronous, bouncing push-button and switch pins into clean clock-domain signals.
- Per bit: 2-flop synchronizer, saturating debounce counter driven by a shared sample-tick divider, and rising-edge detector.
- Produces debounced levels, single-cycle press pulses, and a `ce` output that wires directly to the counter's clock-enable input.

---
 rtl/button_pkg.sv | 17 +
 rtl/button_conditioner_synchronizer.sv | 27 ++
 rtl/button_conditioner.sv | 111 +++++++++++
 tb/tb_button_conditioner.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants for the button conditioning front end: clock period,
// default debounce timing, and a width helper for the internal counters.
package button_pkg;

    localparam int CLK_PERIOD_NS          = 8;
    localparam int SAMPLE_CNT_MAX_DEFAULT = 62500;  // 500 us at 125 MHz
    localparam int PULSE_CNT_MAX_DEFAULT  = 200;    // 100 ms of stable samples

    // Bits needed to hold n_states distinct values; never less than one bit.
    function automatic int cnt_width(input int n_states);
        return (n_states > 1) ? $clog2(n_states) : 1;
    endfunction

    localparam int SAMPLE_CNT_W_DEFAULT = cnt_width(SAMPLE_CNT_MAX_DEFAULT);
    localparam int PULSE_CNT_W_DEFAULT  = cnt_width(PULSE_CNT_MAX_DEFAULT + 1);

endpackage

// File: rtl/button_conditioner_synchronizer.sv
// Two-stage flop synchronizer for a bus of independent asynchronous bits.
// Each bit is synchronized on its own; no cross-bit coherency is implied.
module synchronizer
    import button_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Button conditioner: synchronizes raw button pins, debounces each bit with a
// saturating counter advanced by a shared free-running sample tick, and emits
// debounced levels plus single-cycle press pulses.
// Optional build macro BUTTON_CE_TOGGLE_EN: when defined, ce toggles on every
// press of bit 0 (run/pause); when undefined, ce follows btn_level[0].
module button_conditioner
    import button_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int SAMPLE_CNT_MAX = SAMPLE_CNT_MAX_DEFAULT,
    parameter int PULSE_CNT_MAX  = PULSE_CNT_MAX_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_pulse,
    output logic             ce
);

    localparam int SW = cnt_width(SAMPLE_CNT_MAX);
    localparam int PW = cnt_width(PULSE_CNT_MAX + 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
    localparam logic [PW-1:0] PULSE_FULL  = PW'(PULSE_CNT_MAX);

    logic [WIDTH-1:0] sync;
    logic [SW-1:0]    sample_cnt;
    logic             sample_tick;
    logic [PW-1:0]    deb_cnt [WIDTH];
    logic [WIDTH-1:0] level_next;

    synchronizer #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (sync)
    );

    // The tick marks the last count of each sample period.
    assign sample_tick = (sample_cnt == SAMPLE_LAST);

    // Free-running sample divider shared by every bit; button state never stalls it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
        end else if (sample_tick) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + SW'(1);
        end
    end

    // Per-bit debounce: any low sample clears immediately, high samples count
    // ticks up to saturation so a long hold never wraps into a second press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!sync[i]) begin
                    deb_cnt[i] <= '0;
                end else if (sample_tick && (deb_cnt[i] < PULSE_FULL)) begin
                    deb_cnt[i] <= deb_cnt[i] + PW'(1);
                end
            end
        end
    end

    // A bit is considered pressed once its counter has saturated.
    always_comb begin
        level_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            level_next[i] = (deb_cnt[i] == PULSE_FULL);
        end
    end

    // Level and rising-edge registers update together, so a pulse lines up
    // with the first cycle of its level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level <= '0;
            btn_pulse <= '0;
        end else begin
            btn_level <= level_next;
            btn_pulse <= level_next & ~btn_level;
        end
    end

`ifdef BUTTON_CE_TOGGLE_EN
    logic ce_q;

    // Each press of bit 0 flips the downstream counter between running and paused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_q <= 1'b0;
        end else if (btn_pulse[0]) begin
            ce_q <= ~ce_q;
        end
    end

    assign ce = ce_q;
`else
    // Counter runs only while bit 0 is held down.
    assign ce = btn_level[0];
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner at small timing (SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3).
// The reference model records every clocked input since reset and decides a
// bit's level by walking back through its synchronized history, counting
// sample ticks in the current unbroken high run.
`timescale 1ns/1ps
module tb_button_conditioner;
    import button_pkg::*;

    localparam int W  = 4;
    localparam int S  = 4;
    localparam int P  = 3;
    localparam int EW = 2 * W + 1;

    // ---------------- clock / reset / DUT ----------------
    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] btn_in = '0;
    logic [W-1:0] btn_level;
    logic [W-1:0] btn_pulse;
    logic         ce;

    always #(CLK_PERIOD_NS / 2) clk = ~clk;

    button_conditioner #(
        .WIDTH          (W),
        .SAMPLE_CNT_MAX (S),
        .PULSE_CNT_MAX  (P)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .ce        (ce)
    );

    // Input value seen at each rising edge since the last reset (index 0 = first edge).
    logic [W-1:0] hist[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist.delete();
        else        hist.push_back(btn_in);
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            n_compared = 0;
    int            n_mismatch = 0;
    logic          ce_model   = 1'b0;
    int            pulse_cnt   [W];
    int            first_pulse [W];
    logic [W-1:0]  level_seen;

    // ---------------- reference model ----------------
    // Input clocked at edge n (n >= 1); zero before the first edge.
    function automatic logic [W-1:0] get_in(input int n);
        if (n >= 1 && n <= hist.size()) return hist[n-1];
        return '0;
    endfunction

    // Level after edge k: the counter behind it saw synchronized samples up to
    // edge k-2; the synchronized value at step j is the input from edge j-1,
    // and step j carries a sample tick when j mod S == S-1.
    function automatic logic model_level(input int i, input int k);
        int           ticks;
        logic [W-1:0] v;
        ticks = 0;
        for (int j = k - 2; j >= 2; j--) begin
            v = get_in(j - 1);
            if (!v[i]) return 1'b0;
            if ((j % S) == S - 1) ticks++;
            if (ticks >= P) return 1'b1;
        end
        return 1'b0;
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic compare_vec(input string tag, input logic [EW-1:0] obs);
        logic [EW-1:0] exp_v;
        exp_v = exp_q.pop_front();
        n_compared++;
        assert (obs === exp_v) else begin
            n_mismatch++;
            $error("FAIL %s k=%0d observed{ce,pulse,level}=%h expected=%h",
                   tag, hist.size(), obs, exp_v);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp_v);
        n_compared++;
        assert (obs === exp_v) else begin
            n_mismatch++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_cycle();
        int           k;
        logic [W-1:0] lv;
        logic [W-1:0] pl;
        logic         cv;
        k = hist.size();
        for (int i = 0; i < W; i++) begin
            lv[i] = model_level(i, k);
            pl[i] = lv[i] & ~model_level(i, k - 1);
        end
`ifdef BUTTON_CE_TOGGLE_EN
        if (pl[0]) ce_model = ~ce_model;
        cv = ce_model;
`else
        cv = lv[0];
`endif
        exp_q.push_back({cv, pl, lv});
        compare_vec("cycle", {ce, btn_pulse, btn_level});
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_track();
        for (int i = 0; i < W; i++) begin
            pulse_cnt[i]   = 0;
            first_pulse[i] = -1;
        end
        level_seen = '0;
    endtask

    // Advance n cycles, checking against the model at every falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            check_cycle();
            for (int i = 0; i < W; i++) begin
                if (btn_pulse[i]) begin
                    pulse_cnt[i]++;
                    if (first_pulse[i] < 0) first_pulse[i] = hist.size();
                end
                if (btn_level[i]) level_seen[i] = 1'b1;
            end
        end
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        ce_model = 1'b0;
        exp_q.push_back('0);
        compare_vec("reset_assert", {ce, btn_pulse, btn_level});
        repeat (n) @(negedge clk);
        exp_q.push_back('0);
        compare_vec("reset_hold", {ce, btn_pulse, btn_level});
        rst_n = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int k0;
        int k_rel;

        // Reset with all buttons already held: a fresh debounce is required.
        btn_in = 4'hF;
        clear_track();
        apply_reset(3);
        step(20);
        check_int("reset_pulse_min", int'(first_pulse[0] >= 10), 1);
        check_int("reset_pulse_max", int'(first_pulse[0] <= 16), 1);
        for (int i = 0; i < W; i++) check_int("reset_pulse_count", pulse_cnt[i], 1);
        check_int("reset_pulse_aligned", first_pulse[3], first_pulse[0]);
        btn_in = '0;
        step(8);

        // Clean press of bit 0 with a random idle lead-in.
        step($urandom_range(0, 5));
        clear_track();
        k0 = hist.size();
        btn_in = 4'b0001;
        step(40);
        check_int("press_pulse_count", pulse_cnt[0], 1);
        check_int("press_latency", int'(first_pulse[0] - k0 <= 16), 1);
        btn_in = '0;
        k_rel = hist.size();
        step(3);
        check_int("release_level_hold", int'(btn_level[0]), 1);
        step(1);
        check_int("release_level_drop", int'(btn_level[0]), 0);
        check_int("release_latency", hist.size() - k_rel, 4);
        step(10);
        check_int("press_no_second_pulse", pulse_cnt[0], 1);

        // Bounce on bit 1: toggle every 3 cycles, then random short bursts.
        clear_track();
        for (int t = 0; t < 10; t++) begin
            btn_in[1] = ~btn_in[1];
            step(3);
        end
        btn_in = '0;
        step(6);
        for (int t = 0; t < 8; t++) begin
            btn_in[1] = 1'b1;
            step($urandom_range(1, 8));
            btn_in[1] = 1'b0;
            step($urandom_range(1, 4));
        end
        step(10);
        check_int("bounce_pulse", pulse_cnt[1], 0);
        check_int("bounce_level", int'(level_seen[1]), 0);

        // Simultaneous press on bits 1 and 2.
        clear_track();
        btn_in = 4'b0110;
        step(25);
        check_int("simul_pulse1", pulse_cnt[1], 1);
        check_int("simul_pulse2", pulse_cnt[2], 1);
        check_int("simul_same_cycle", first_pulse[2], first_pulse[1]);
        check_int("simul_bit0_quiet", pulse_cnt[0], 0);
        check_int("simul_bit3_quiet", pulse_cnt[3], 0);
        btn_in = '0;
        step(8);

        // Mid-press reset after two ticks of a held press on bit 0.
        while ((hist.size() % S) != 0) step(1);
        btn_in = 4'b0001;
        step(9);
        check_int("midpress_level_before", int'(btn_level[0]), 0);
        clear_track();
        apply_reset(2);
        step(20);
        check_int("midpress_pulse_min", int'(first_pulse[0] >= 10), 1);
        check_int("midpress_pulse_max", int'(first_pulse[0] <= 16), 1);
        check_int("midpress_pulse_count", pulse_cnt[0], 1);
        btn_in = '0;
        step(8);

        // ce behaviour across three presses of bit 0, from a clean reset.
        apply_reset(1);
        for (int p = 0; p < 3; p++) begin
            btn_in = 4'b0001;
            step(20);
`ifdef BUTTON_CE_TOGGLE_EN
            check_int("ce_after_press", int'(ce), (p + 1) % 2);
`else
            check_int("ce_after_press", int'(ce), 1);
`endif
            btn_in = '0;
            step(8);
`ifdef BUTTON_CE_TOGGLE_EN
            check_int("ce_after_release", int'(ce), (p + 1) % 2);
`else
            check_int("ce_after_release", int'(ce), 0);
`endif
        end

        // Random hold patterns across all bits.
        for (int t = 0; t < 30; t++) begin
            btn_in = W'($urandom_range(0, (1 << W) - 1));
            step($urandom_range(1, 20));
        end
        btn_in = '0;
        step(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
